// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : decoder_rr_arbiter
// Description : Four-requester round-robin arbiter with hold-limit revocation,
//               one-cycle release gap and decoded one-hot grant output.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout,
    output logic       busy
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_grant   = 2'd1;
    localparam logic [1:0] c_st_release = 2'd2;
    localparam logic [7:0] c_hold_last  = 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_grant_id;
    logic [1:0] r_last_id;
    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    logic [1:0] w_winner;
    logic [1:0] w_idx;
    logic       w_found;
    logic       w_hold_last;
    logic       w_exit;
    logic       w_hold_only;

    // Search starts just past the previous owner, so it becomes lowest priority.
    always_comb begin
        w_winner = r_last_id;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last_id + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_hold_last = (r_hold_cnt == c_hold_last);
    assign w_exit      = done | ~req[r_grant_id] | w_hold_last;
    assign w_hold_only = w_hold_last & ~done & req[r_grant_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (|req) w_state_nxt = c_st_grant;
            c_st_grant:   if (w_exit) w_state_nxt = c_st_release;
            c_st_release: w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id <= 2'd0;
            r_last_id  <= 2'd3;
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (|req) begin
                        r_grant_id <= w_winner;
                        r_hold_cnt <= 8'd0;
                    end
                end
                c_st_grant: begin
                    if (w_exit) begin
                        r_last_id <= r_grant_id;
                        r_timeout <= w_hold_only;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_valid = (r_state == c_st_grant);
    assign grant       = grant_valid ? (4'b0001 << r_grant_id) : 4'b0000;
    assign grant_id    = grant_valid ? r_grant_id : 2'd0;
    assign timeout     = r_timeout;
    assign busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire
